// File: rtl/pkt_framer.sv
// Packet source: turns a length request into a HEAD/(DATA)*/TAIL flit stream
// with downstream stall support and a fixed idle gap after every tail.
module pkt_framer #(
    parameter int LEN_W  = 8,
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [LEN_W-1:0]  req_len,
    output logic              req_ready,
    input  logic              stall,
    output logic              head,
    output logic              tail,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              len_err
);

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_DATA, S_TAIL, S_GAP} state_t;

    localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  rem, rem_nxt, len_q, len_q_nxt;
    logic [DATA_W-1:0] seq, seq_nxt, data_nxt;
    logic [3:0]        gap_cnt, gap_nxt;
    logic              head_nxt, tail_nxt, valid_nxt, len_err_nxt;

    assign req_ready = (state == S_IDLE) && !reset;

    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem;
        len_q_nxt   = len_q;
        seq_nxt     = seq;
        data_nxt    = data;
        gap_nxt     = gap_cnt;
        head_nxt    = 1'b0;
        tail_nxt    = 1'b0;
        valid_nxt   = 1'b0;
        len_err_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_len >= LEN_W'(2)) begin
                        rem_nxt   = req_len - LEN_W'(2);
                        len_q_nxt = req_len;
                        state_nxt = S_HEAD;
                    end else begin
                        len_err_nxt = 1'b1;
                    end
                end
            end
            S_HEAD: begin
                if (!stall) begin
                    valid_nxt = 1'b1;
                    head_nxt  = 1'b1;
                    data_nxt  = DATA_W'(len_q);
                    state_nxt = (rem == '0) ? S_TAIL : S_DATA;
                end
            end
            S_DATA: begin
                if (!stall) begin
                    valid_nxt = 1'b1;
                    data_nxt  = seq;
                    seq_nxt   = seq + DATA_W'(1);
                    rem_nxt   = rem - LEN_W'(1);
                    // rem is >= 1 on entry, so this is the last middle flit
                    if (rem == LEN_W'(1))
                        state_nxt = S_TAIL;
                end
            end
            S_TAIL: begin
                if (!stall) begin
                    valid_nxt = 1'b1;
                    tail_nxt  = 1'b1;
                    data_nxt  = seq;
                    seq_nxt   = seq + DATA_W'(1);
                    if (GAP > 0) begin
                        state_nxt = S_GAP;
                        gap_nxt   = GAP_LD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                // gap counting ignores stall: no flit is offered here anyway
                if (gap_cnt == 4'd0) state_nxt = S_IDLE;
                else                 gap_nxt   = gap_cnt - 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            rem     <= '0;
            len_q   <= '0;
            seq     <= '0;
            gap_cnt <= '0;
            head    <= 1'b0;
            tail    <= 1'b0;
            valid   <= 1'b0;
            data    <= '0;
            busy    <= 1'b0;
            len_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            rem     <= rem_nxt;
            len_q   <= len_q_nxt;
            seq     <= seq_nxt;
            gap_cnt <= gap_nxt;
            head    <= head_nxt;
            tail    <= tail_nxt;
            valid   <= valid_nxt;
            data    <= data_nxt;
            busy    <= (state_nxt != S_IDLE);
            len_err <= len_err_nxt;
        end
    end

endmodule

// File: tb/tb_pkt_framer.sv
// Directed bench for pkt_framer: one instance with GAP=1, one with GAP=0.
module tb_pkt_framer;

    logic       clock = 1'b0;
    logic       reset, req_valid, req_valid0, stall;
    logic [7:0] req_len;
    logic       req_ready, head, tail, valid, busy, len_err;
    logic [7:0] data;
    logic       req_ready0, head0, tail0, valid0, busy0, len_err0;
    logic [7:0] data0;
    int         checks = 0;
    int         failures = 0;

    always #5 clock = ~clock;

    pkt_framer #(.LEN_W(8), .DATA_W(8), .GAP(1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_len(req_len),
        .req_ready(req_ready), .stall(stall), .head(head), .tail(tail),
        .valid(valid), .data(data), .busy(busy), .len_err(len_err)
    );

    pkt_framer #(.LEN_W(8), .DATA_W(8), .GAP(0)) dut0 (
        .clock(clock), .reset(reset), .req_valid(req_valid0), .req_len(req_len),
        .req_ready(req_ready0), .stall(stall), .head(head0), .tail(tail0),
        .valid(valid0), .data(data0), .busy(busy0), .len_err(len_err0)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // {valid,head,tail,busy,len_err,req_ready}
    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_len = 8'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid, head, tail, busy, len_err, req_ready} !== 6'b000000) begin
                failures++;
                $display("FAIL reset_outs cyc=%0d got=%b want=000000", i,
                         {valid, head, tail, busy, len_err, req_ready});
            end
        end
        reset = 1'b0; req_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b want=1", req_ready);
        end
    endtask

    // {valid,head,tail,busy}
    task automatic test_basic();
        logic [3:0] ev [6] = '{4'b0001, 4'b1101, 4'b1001, 4'b1001, 4'b1011, 4'b0000};
        logic [7:0] ed [6] = '{8'h00, 8'h04, 8'h00, 8'h01, 8'h02, 8'h02};
        req_valid = 1'b1; req_len = 8'd4;
        for (int i = 0; i < 6; i++) begin
            tick();
            req_valid = 1'b0;
            checks++;
            if ({valid, head, tail, busy} !== ev[i] || (ev[i][3] && data !== ed[i])) begin
                failures++;
                $display("FAIL basic cyc=%0d got vhtb=%b data=%h want vhtb=%b data=%h",
                         i, {valid, head, tail, busy}, data, ev[i], ed[i]);
            end
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready_after_gap got=%b want=1", req_ready);
        end
    endtask

    task automatic test_min_packet();
        req_valid = 1'b1; req_len = 8'd2;
        tick();
        req_valid = 1'b0;
        tick();
        checks++;
        if ({valid, head, tail} !== 3'b110 || data !== 8'h02) begin
            failures++;
            $display("FAIL min_head got vht=%b data=%h want vht=110 data=02",
                     {valid, head, tail}, data);
        end
        tick();
        checks++;
        if ({valid, head, tail} !== 3'b101 || data !== 8'h03) begin
            failures++;
            $display("FAIL min_tail got vht=%b data=%h want vht=101 data=03",
                     {valid, head, tail}, data);
        end
        tick();
        checks++;
        if ({valid, busy, req_ready} !== 3'b001) begin
            failures++;
            $display("FAIL min_idle got vbr=%b want 001", {valid, busy, req_ready});
        end
    endtask

    task automatic test_len_err();
        req_valid = 1'b1; req_len = 8'd1;
        tick();
        checks++;
        if ({len_err, valid, busy, req_ready} !== 4'b1001) begin
            failures++;
            $display("FAIL len_err_1 got evbr=%b want 1001", {len_err, valid, busy, req_ready});
        end
        req_len = 8'd0;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({len_err, valid, busy, req_ready} !== 4'b1001) begin
            failures++;
            $display("FAIL len_err_0 got evbr=%b want 1001", {len_err, valid, busy, req_ready});
        end
        tick();
        checks++;
        if ({len_err, valid, busy, req_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL len_err_clear got evbr=%b want 0001", {len_err, valid, busy, req_ready});
        end
    endtask

    task automatic test_stall();
        logic       sv [9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
        logic [3:0] ev [9] = '{4'b1101, 4'b1001, 4'b0001, 4'b0001, 4'b0001,
                               4'b1001, 4'b1001, 4'b1011, 4'b0000};
        logic [7:0] ed [9] = '{8'h05, 8'h04, 8'h04, 8'h04, 8'h04,
                               8'h05, 8'h06, 8'h07, 8'h07};
        int nflits = 0;
        req_valid = 1'b1; req_len = 8'd5;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            stall = sv[i];
            tick();
            if (valid) nflits++;
            checks++;
            if ({valid, head, tail, busy} !== ev[i] || data !== ed[i]) begin
                failures++;
                $display("FAIL stall cyc=%0d got vhtb=%b data=%h want vhtb=%b data=%h",
                         i, {valid, head, tail, busy}, data, ev[i], ed[i]);
            end
        end
        stall = 1'b0;
        checks++;
        if (nflits != 5) begin
            failures++;
            $display("FAIL stall_flit_count got=%0d want=5", nflits);
        end
    endtask

    task automatic test_abort();
        req_valid = 1'b1; req_len = 8'd6;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({valid, head, tail} !== 3'b100 || data !== 8'h08) begin
            failures++;
            $display("FAIL abort_data got vht=%b data=%h want vht=100 data=08",
                     {valid, head, tail}, data);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({valid, head, tail, busy, len_err, req_ready} !== 6'b0 || data !== 8'h00) begin
            failures++;
            $display("FAIL abort_reset got=%b data=%h want=000000 data=00",
                     {valid, head, tail, busy, len_err, req_ready}, data);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid, tail, busy, req_ready} !== 4'b0001) begin
                failures++;
                $display("FAIL abort_no_tail cyc=%0d got vtbr=%b want 0001",
                         i, {valid, tail, busy, req_ready});
            end
        end
    endtask

    // GAP=0 instance; its seq was cleared by the abort reset
    task automatic test_back_to_back();
        logic [2:0] ev [6] = '{3'b000, 3'b110, 3'b100, 3'b101, 3'b000, 3'b110};
        logic [7:0] ed [6] = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h01, 8'h02};
        req_valid0 = 1'b1; req_len = 8'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            req_valid0 = 1'b0;
            checks++;
            if ({valid0, head0, tail0} !== ev[i] || data0 !== ed[i]) begin
                failures++;
                $display("FAIL b2b cyc=%0d got vht=%b data=%h want vht=%b data=%h",
                         i, {valid0, head0, tail0}, data0, ev[i], ed[i]);
            end
            if (i == 3) begin
                checks++;
                if (req_ready0 !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready_at_tail got=%b want=1", req_ready0);
                end
                req_valid0 = 1'b1; req_len = 8'd2;
            end
        end
        tick();
        checks++;
        if ({valid0, head0, tail0} !== 3'b101 || data0 !== 8'h02) begin
            failures++;
            $display("FAIL b2b_tail2 got vht=%b data=%h want vht=101 data=02",
                     {valid0, head0, tail0}, data0);
        end
    endtask

    initial begin
        req_valid0 = 1'b0; stall = 1'b0;
        test_reset();
        test_basic();
        test_min_packet();
        test_len_err();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/pkt_framer.md
Name: pkt_framer

Overview:
Packet source stage that sits directly upstream of the packet-protocol FSM checker. It accepts a packet request carrying a flit count and emits a framed flit stream on head/tail/valid/data. The stream follows the IDLE->HEAD->(DATA)*->TAIL->(HEAD|IDLE) protocol that the downstream FSM tracks. It supports a downstream stall and enforces a minimum inter-packet gap.

Parameters:
LEN_W, 8, width of the requested packet length (flit count)
DATA_W, 8, width of the flit data bus
GAP, 1, number of idle cycles (valid=0) after each tail flit before the next request is accepted; range 0..15

Ports:
clock  input  1  single clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  packet request present
req_len  input  LEN_W  total flits in the packet, including head and tail
req_ready  output  1  framer can accept a request this cycle
stall  input  1  downstream hold; while 1, no flit is emitted and progress freezes
head  output  1  current flit is the head flit (qualified by valid)
tail  output  1  current flit is the tail flit (qualified by valid)
valid  output  1  flit present on data/head/tail
data  output  DATA_W  flit payload
busy  output  1  a packet or its trailing gap is in progress
len_err  output  1  one-cycle pulse: the request was rejected because req_len < 2

Behaviour:
- Reset is synchronous and active-high. On a clock edge with reset=1: state=IDLE, and head, tail, valid, data, busy and len_err all go to 0. Counters clear.
- req_ready is combinational: 1 only when state==IDLE and reset==0.
- All other outputs are registered.
- States:
  - IDLE
  - HEAD: head flit pending
  - DATA: middle flits pending
  - TAIL: tail flit pending
  - GAP: post-tail idle count
- Accept: at an edge with state==IDLE, req_valid=1 and reset=0.
  - req_len >= 2: capture rem = req_len-2 and move to HEAD. On the following edge (stall=0), drive valid=1, head=1, data=req_len[DATA_W-1:0] (zero-extended or truncated to fit). Latency from the accept edge to the head flit appearing is 1 cycle.
  - req_len in {0,1}: the request is consumed and dropped. len_err=1 for exactly one cycle, state stays IDLE, no flits are emitted.
- Flit emission happens only on edges where stall=0. On a stall=1 edge: valid=head=tail=0, and state, rem and seq hold. The stall is never seen inside a flit: each flit is a single cycle with valid=1.
- HEAD emit: if rem==0, next state is TAIL; otherwise next state is DATA.
- DATA emit: drive valid=1, head=0, tail=0, data=seq. Then seq increments (wraps modulo 2^DATA_W) and rem decrements. Leave DATA when the emission that brings rem to 0 completes; next state is TAIL.
- TAIL emit: drive valid=1, tail=1, data=seq. seq increments. Next state is GAP if GAP>0, otherwise IDLE.
- In a cycle with no emission (IDLE, GAP, or stalled), valid=head=tail=0 and data holds its last value.
- head and tail are never 1 in the same cycle. The minimum packet is head followed by tail.
- GAP: count GAP cycles with valid=0 (stall is ignored), then go to IDLE. With GAP=0, a back-to-back request is accepted in the cycle the tail is visible, so the next head follows the tail with exactly 1 idle cycle.
- seq is a DATA_W-bit per-module counter. It clears only on reset and persists across packets.
- busy=1 in HEAD, DATA, TAIL and GAP; busy=0 in IDLE.
- Reset mid-packet aborts the packet immediately. No tail is emitted, and all outputs are 0 on the next cycle.
- Maximum req_len is 2^LEN_W-1. rem is LEN_W bits wide and never underflows.

Test Plan:
- Reset: hold reset=1 for 3 cycles with req_valid=1 -> valid=head=tail=busy=len_err=0 and req_ready=0 throughout; after release, req_ready=1.
- Basic packet: req_len=4, GAP=1, no stall -> 4 consecutive valid cycles with head,data=04 / data=00 / data=01 / tail,data=02. Then 1 idle cycle, then req_ready=1.
- Minimum packet: req_len=2 -> head (data=02) then tail on the next cycle. The downstream FSM walks IDLE->HEAD->TAIL->IDLE.
- Length error: req_len=1, then req_len=0 -> len_err pulses one cycle each, valid stays 0, busy stays 0, state stays IDLE.
- Stall: req_len=5 with stall=1 for 3 cycles after the first data flit -> valid=0 during the stall, no flit lost or duplicated, data sequence continues unbroken, total of 5 valid flits.
- Abort and back-to-back: reset asserted during the DATA flit of a req_len=6 packet -> no tail, all outputs 0. Then two requests with GAP=0 -> the second head appears exactly 1 cycle after the first tail.
